// File: rtl/minimo_conditioner.sv
`default_nettype none
// ============================================================================
// minimo_conditioner : 2-FF synchronizer + debounce FSM for the minimo_2 pin,
//                      with rise/fall strobes and a wrapping rise counter.
// Revision 1.0
// ============================================================================
module minimo_conditioner #(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int CNT_WIDTH       = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 din,
  input  logic                 clr,
  output logic                 level,
  output logic                 rise,
  output logic                 fall,
  output logic [CNT_WIDTH-1:0] count,
  output logic                 overflow
);

  localparam int DCNT_W = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [DCNT_W-1:0]    c_DCNT_LAST = DCNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [DCNT_W-1:0]    c_DCNT_ONE  = DCNT_W'(1);
  localparam logic [CNT_WIDTH-1:0] c_CNT_MAX   = {CNT_WIDTH{1'b1}};
  localparam logic [CNT_WIDTH-1:0] c_CNT_ONE   = CNT_WIDTH'(1);

  typedef enum logic [1:0] {
    STABLE_LOW  = 2'd0,
    WAIT_HIGH   = 2'd1,
    STABLE_HIGH = 2'd2,
    WAIT_LOW    = 2'd3
  } state_t;

  logic                 sync1_q, sync1_d;
  logic                 sync2_q, sync2_d;
  state_t               state_q, state_d;
  logic [DCNT_W-1:0]    dcnt_q, dcnt_d;
  logic                 level_q, level_d;
  logic                 rise_q, rise_d;
  logic                 fall_q, fall_d;
  logic [CNT_WIDTH-1:0] count_q, count_d;
  logic                 overflow_q, overflow_d;
  logic [CNT_WIDTH-1:0] count_base;
  logic                 overflow_base;

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q    <= 1'b0;
      sync2_q    <= 1'b0;
      state_q    <= STABLE_LOW;
      dcnt_q     <= '0;
      level_q    <= 1'b0;
      rise_q     <= 1'b0;
      fall_q     <= 1'b0;
      count_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      sync1_q    <= sync1_d;
      sync2_q    <= sync2_d;
      state_q    <= state_d;
      dcnt_q     <= dcnt_d;
      level_q    <= level_d;
      rise_q     <= rise_d;
      fall_q     <= fall_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
    end
  end

  always_comb begin
    sync1_d = din;
    sync2_d = sync1_q;
  end

  // dcnt counts consecutive synchronized samples that disagree with level.
  always_comb begin
    state_d = state_q;
    dcnt_d  = dcnt_q;
    level_d = level_q;
    rise_d  = 1'b0;
    fall_d  = 1'b0;
    case (state_q)
      STABLE_LOW: begin
        if (sync2_q) begin
          state_d = WAIT_HIGH;
          dcnt_d  = c_DCNT_ONE;
        end
      end
      WAIT_HIGH: begin
        if (!sync2_q) begin
          state_d = STABLE_LOW;
          dcnt_d  = '0;
        end else if (dcnt_q == c_DCNT_LAST) begin
          state_d = STABLE_HIGH;
          dcnt_d  = '0;
          level_d = 1'b1;
          rise_d  = 1'b1;
        end else begin
          dcnt_d = dcnt_q + c_DCNT_ONE;
        end
      end
      STABLE_HIGH: begin
        if (!sync2_q) begin
          state_d = WAIT_LOW;
          dcnt_d  = c_DCNT_ONE;
        end
      end
      WAIT_LOW: begin
        if (sync2_q) begin
          state_d = STABLE_HIGH;
          dcnt_d  = '0;
        end else if (dcnt_q == c_DCNT_LAST) begin
          state_d = STABLE_LOW;
          dcnt_d  = '0;
          level_d = 1'b0;
          fall_d  = 1'b1;
        end else begin
          dcnt_d = dcnt_q + c_DCNT_ONE;
        end
      end
      default: begin
        state_d = STABLE_LOW;
        dcnt_d  = '0;
      end
    endcase
  end

  // Clear is applied before a coincident rise is counted.
  always_comb begin
    count_base    = clr ? '0 : count_q;
    overflow_base = clr ? 1'b0 : overflow_q;
    count_d       = count_base;
    overflow_d    = overflow_base;
    if (rise_d) begin
      count_d = count_base + c_CNT_ONE;
      if (count_base == c_CNT_MAX) begin
        overflow_d = 1'b1;
      end
    end
  end

  assign level    = level_q;
  assign rise     = rise_q;
  assign fall     = fall_q;
  assign count    = count_q;
  assign overflow = overflow_q;

endmodule
`default_nettype wire

// File: tb/tb_minimo_conditioner.sv
`default_nettype none
// ============================================================================
// tb_minimo_conditioner : scoreboard bench with a history-window reference
//                         model for the minimo_2 input conditioner.
// Revision 1.0
// ============================================================================
module tb_minimo_conditioner;

  localparam int D = 4;
  localparam int W = 3;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         din = 1'b0;
  logic         clr = 1'b0;
  logic         level, rise, fall, overflow;
  logic [W-1:0] count;

  minimo_conditioner #(
    .DEBOUNCE_CYCLES(D),
    .CNT_WIDTH      (W)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .din     (din),
    .clr     (clr),
    .level   (level),
    .rise    (rise),
    .fall    (fall),
    .count   (count),
    .overflow(overflow)
  );

  always #10 clk = ~clk;

  typedef struct packed {
    logic         level;
    logic         rise;
    logic         fall;
    logic [W-1:0] count;
    logic         overflow;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   cyc      = 0;
  bit   done     = 1'b0;

  // Reference model: the level flips once the last D synchronized samples
  // all disagree with it; the synchronizer is a plain two-sample delay.
  bit          m_p1, m_p2, m_level, m_ovf;
  int unsigned m_count;
  bit          hist[$];

  task automatic model_step();
    exp_t e;
    bit   s;
    bit   flip;
    e    = '0;
    flip = 1'b0;
    cyc++;
    if (rst) begin
      m_p1 = 0; m_p2 = 0; m_level = 0; m_count = 0; m_ovf = 0;
      hist.delete();
    end else begin
      s    = m_p2;
      m_p2 = m_p1;
      m_p1 = din;
      hist.push_back(s);
      if (hist.size() > D) void'(hist.pop_front());
      if (hist.size() == D) begin
        flip = 1'b1;
        foreach (hist[i]) if (hist[i] == m_level) flip = 1'b0;
      end
      if (clr) begin
        m_count = 0;
        m_ovf   = 0;
      end
      if (flip) begin
        m_level = !m_level;
        hist.delete();
        e.rise = m_level;
        e.fall = !m_level;
      end
      if (e.rise) begin
        m_count++;
        if (m_count == (1 << W)) begin
          m_count = 0;
          m_ovf   = 1;
        end
      end
    end
    e.level    = m_level;
    e.count    = W'(m_count);
    e.overflow = m_ovf;
    exp_q.push_back(e);
  endtask

  initial begin
    forever begin
      @(posedge clk);
      model_step();
    end
  end

  // Monitor: the DUT presents a fresh output set every cycle.
  initial begin
    exp_t e;
    exp_t a;
    while (!done) begin
      @(negedge clk);
      if (!done) begin
        a.level    = level;
        a.rise     = rise;
        a.fall     = fall;
        a.count    = count;
        a.overflow = overflow;
        n_checks++;
        if (exp_q.size() == 0) begin
          n_fail++;
          $display("FAIL scoreboard_empty t=%0t: got level=%b rise=%b fall=%b count=%0d ovf=%b, no expected entry",
                   $time, a.level, a.rise, a.fall, a.count, a.overflow);
        end else begin
          e = exp_q.pop_front();
          if (a !== e) begin
            n_fail++;
            $display("FAIL cycle_%0d: got level=%b rise=%b fall=%b count=%0d ovf=%b, expected level=%b rise=%b fall=%b count=%0d ovf=%b",
                     cyc, a.level, a.rise, a.fall, a.count, a.overflow,
                     e.level, e.rise, e.fall, e.count, e.overflow);
          end
        end
      end
    end
  end

  task automatic check(input string name, input int got, input int expv);
    n_checks++;
    if (got !== expv) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, got, expv);
    end
  endtask

  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic press(input int hi, input int lo);
    din = 1'b1;
    cycles(hi);
    din = 1'b0;
    cycles(lo);
  endtask

  task automatic pulse_clr();
    clr = 1'b1;
    cycles(1);
    clr = 1'b0;
  endtask

  initial begin
    // Reset release with din already high
    rst = 1'b1;
    din = 1'b1;
    cycles(4);
    check("reset_level", level, 0);
    check("reset_count", count, 0);
    rst = 1'b0;
    cycles(5);
    check("release_level_edge5", level, 0);
    cycles(1);
    check("release_level_edge6", level, 1);
    check("release_rise_edge6", rise, 1);
    check("release_count", count, 1);
    cycles(1);
    check("release_rise_one_cycle", rise, 0);
    din = 1'b0;
    cycles(10);

    // Glitch train, asynchronous to the clock
    pulse_clr();
    repeat (4) begin
      din = 1'b1;
      #40;
      din = 1'b0;
      #22;
    end
    din = 1'b0;
    @(negedge clk);
    cycles(10);
    check("glitch_level", level, 0);
    check("glitch_count", count, 0);

    // Clean press and release
    press(10, 10);
    check("press_count", count, 1);

    // Wrap of the narrow counter
    pulse_clr();
    repeat (8) press(6, 6);
    check("wrap_count", count, 0);
    check("wrap_overflow", overflow, 1);
    press(6, 6);
    check("post_wrap_count", count, 1);
    check("post_wrap_overflow", overflow, 1);

    // Clear coincident with a rise
    repeat (4) press(6, 6);
    check("pre_clr_count", count, 5);
    check("pre_clr_overflow", overflow, 1);
    din = 1'b1;
    cycles(5);
    clr = 1'b1;
    cycles(1);
    clr = 1'b0;
    check("clr_rise_rise", rise, 1);
    check("clr_rise_count", count, 1);
    check("clr_rise_overflow", overflow, 0);
    din = 1'b0;
    cycles(8);

    // Reset while debouncing a rising edge
    din = 1'b1;
    cycles(4);
    rst = 1'b1;
    cycles(1);
    rst = 1'b0;
    check("midreset_level", level, 0);
    cycles(5);
    check("midreset_level_edge5", level, 0);
    cycles(1);
    check("midreset_rise", rise, 1);
    check("midreset_count", count, 1);
    din = 1'b0;
    cycles(8);

    // Randomized phase
    for (int i = 0; i < 2000; i++) begin
      int hold;
      din  = 1'($urandom_range(0, 1));
      hold = $urandom_range(1, 8);
      for (int k = 0; k < hold; k++) begin
        clr = ($urandom_range(0, 19) == 0);
        rst = ($urandom_range(0, 299) == 0);
        cycles(1);
      end
    end
    clr = 1'b0;
    rst = 1'b0;
    din = 1'b0;
    cycles(2);
    done = 1'b1;
    @(posedge clk);
    #1;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/minimo_conditioner.md
Name: minimo_conditioner

Overview:
Input conditioner that sits directly upstream of the system block's minimo_2 input. It takes the raw asynchronous minimo_2 line (push-button or sensor) and delivers a clean signal: 2-FF synchronizer, then a debounce state machine. It outputs the debounced level, single-cycle rise/fall strobes and a rising-edge event counter. The system block consumes the level and rise outputs instead of the raw pin.

Parameters:
debounce_cycles, 4, consecutive synchronized cycles the input must differ from the current level before the level flips; must be >= 2 (use clk_freq/1000 for a 1 ms window in synthesis)
cnt_width, 8, width of the rising-edge event counter

Ports:
clk  input  1  system clock, all logic on rising edge
rst  input  1  synchronous reset, active-high
din  input  1  raw minimo_2 pin, asynchronous to clk
clr  input  1  synchronous clear of count and overflow
level  output  1  debounced level of din
rise  output  1  one-cycle strobe on debounced 0->1
fall  output  1  one-cycle strobe on debounced 1->0
count  output  cnt_width  number of debounced rising edges since reset/clr, wraps
overflow  output  1  sticky, set when count wraps

Behaviour:
- One clock; reset is synchronous and active-high (rst sampled on rising edge of clk).
- Reset (rst=1 at an edge): sync1, sync2, level, rise, fall, count, overflow all 0. State goes to STABLE_LOW. Debounce counter goes to 0. Reset mid-debounce discards the pending transition.
- Synchronizer: sync1<=din, sync2<=sync1. s=sync2. No other logic reads din.
- FSM states: STABLE_LOW, WAIT_HIGH, STABLE_HIGH, WAIT_LOW. The debounce counter dcnt is wide enough to hold debounce_cycles-1.
- STABLE_LOW: if s=1, go to WAIT_HIGH with dcnt<=1; otherwise stay.
- WAIT_HIGH:
  - If s=0: glitch rejected. Go to STABLE_LOW, dcnt<=0, no strobe.
  - Else if dcnt==debounce_cycles-1: go to STABLE_HIGH, level<=1, rise<=1.
  - Else: dcnt<=dcnt+1.
- STABLE_HIGH and WAIT_LOW: mirror of the above with polarity swapped. The completion produces level<=0 and fall<=1.
- Latency: level changes on the (debounce_cycles+2)-th rising edge counting the first edge that samples the new din into sync1. The input must stay stable through that window. With the default, this is the 6th edge, 120 ns at 20 ns tck.
- Minimum accepted pulse width is debounce_cycles clocks at s. Any shorter excursion produces no level change and no strobe.
- rise and fall are registered. Each is high exactly the one cycle in which level first shows its new value, and 0 otherwise. They are never both 1.
- Counter:
  - On a cycle where rise is asserted, count<=count+1 on the same edge that sets rise, so count and rise update together.
  - At count = 2^cnt_width-1, the increment wraps count to 0 and sets overflow<=1. overflow stays set until clr or rst.
- clr=1 with no concurrent increment: count<=0, overflow<=0.
- clr=1 on the same edge as an increment: count<=1, overflow<=0. The clear applies first, then the event counts.
- clr does not affect the FSM, level, rise or fall.
- rst has priority over clr and all other activity.

Test Plan:
1. Reset release: hold rst=1 for 4 cycles with din=1, then release. Required: level=0, count=0, overflow=0 while in reset. level rises on the 6th edge after release, with rise=1 for exactly that cycle and count=1.
2. Glitch train: din alternating 40 ns high / 22 ns low four times (tck=20, debounce_cycles=4), then din=0. Required: level stays 0 and rise never asserts; count stays 0.
3. Clean press and release: din=1 for 200 ns, then 0 for 200 ns. Required: one rise pulse and one fall pulse, each one cycle wide. level high between them for 10 cycles. count=1.
4. Wrap: cnt_width=3, apply 8 clean presses. Required: count goes 1..7, then 0 on the 8th rise, overflow=1. A further press gives count=1 with overflow still 1.
5. Simultaneous clr and rise: assert clr exactly on the edge where rise asserts, with count=5 and overflow=1 beforehand. Required: count=1, overflow=0.
6. Reset mid-debounce: din 0->1, assert rst for 1 cycle while the FSM is in WAIT_HIGH with dcnt=2, keep din=1. Required: no rise before reset. After release, a full new 6-edge latency, then rise=1 and count=1.
